// File: rtl/rvm_adder_arbiter.sv
// rvm_adder_arbiter: round-robin sharing of one rvm_adder
// between the fetch (port 0) and execute (port 1) requesters.
module rvm_adder_arbiter #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] lhs0,
  input  logic [31:0] lhs1,
  input  logic [31:0] rhs0,
  input  logic [31:0] rhs1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [32:0] rsp_result,
  output logic        busy,
  output logic [31:0] add_lhs,
  output logic [31:0] add_rhs,
  output logic [2:0]  add_op,
  input  logic [32:0] add_result
);

  localparam logic [2:0] ARITH_NOP = 3'd0;
  localparam logic [2:0] ARITH_ADD = 3'd1;
  localparam logic [2:0] ARITH_SUB = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic        idx;
    logic [2:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
  } slot_t;

  state_e      state_q;
  state_e      state_d;
  slot_t       slot_q;
  slot_t       slot_sel;
  logic        last_q;
  logic        win;
  logic        accept;
  logic        op_ok;
  logic [32:0] result_q;

  // Tie goes to the port that was not granted last.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      req0 && req1:  win = ~last_q;
      req1 && !req0: win = 1'b1;
      default:       win = 1'b0;
    endcase
  end

  always_comb begin
    slot_sel = '0;
    if (win) begin
      slot_sel.idx = 1'b1;
      slot_sel.op  = op1;
      slot_sel.lhs = lhs1;
      slot_sel.rhs = rhs1;
    end else begin
      slot_sel.idx = 1'b0;
      slot_sel.op  = op0;
      slot_sel.lhs = lhs0;
      slot_sel.rhs = rhs0;
    end
  end

  assign op_ok = (slot_q.op == ARITH_ADD) ||
                 (slot_q.op == ARITH_SUB);

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    add_op     = ARITH_NOP;
    add_lhs    = '0;
    add_rhs    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (resetn && (req0 || req1)) begin
          accept  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        state_d = S_DONE;
        add_op  = op_ok ? slot_q.op : ARITH_NOP;
        add_lhs = slot_q.lhs;
        add_rhs = slot_q.rhs;
      end
      S_DONE: begin
        state_d    = S_IDLE;
        rsp0_valid = ~slot_q.idx;
        rsp1_valid = slot_q.idx;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gnt0       = accept & ~win;
  assign gnt1       = accept & win;
  assign busy       = (state_q != S_IDLE);
  assign rsp_result = result_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_q <= '0;
      last_q <= ~RESET_PRIO;
    end else if (accept) begin
      slot_q <= slot_sel;
      last_q <= win;
    end
  end

  // A NOP or undefined op still completes, but returns zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_q <= '0;
    end else if (state_q == S_CALC) begin
      result_q <= op_ok ? add_result : '0;
    end
  end

endmodule

// File: tb/tb_rvm_adder_arbiter.sv
// tb_rvm_adder_arbiter: vector table plus scoreboard
// for the shared-adder round-robin arbiter.
module tb_rvm_adder_arbiter;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;

  logic        clk;
  logic        resetn;
  logic        req0, req1;
  logic [31:0] lhs0, lhs1, rhs0, rhs1;
  logic [2:0]  op0, op1;
  logic        gnt0, gnt1;
  logic        rsp0_valid, rsp1_valid;
  logic [32:0] rsp_result;
  logic        busy;
  logic [31:0] add_lhs, add_rhs;
  logic [2:0]  add_op;
  logic [32:0] add_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic [2:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [32:0] res;
  } vec_t;

  typedef struct {
    logic        port;
    logic [32:0] res;
  } exp_t;

  vec_t vecs [9];
  exp_t sb [$];

  rvm_adder_arbiter #(.RESET_PRIO(1'b0)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req0       (req0),
    .req1       (req1),
    .lhs0       (lhs0),
    .lhs1       (lhs1),
    .rhs0       (rhs0),
    .rhs1       (rhs1),
    .op0        (op0),
    .op1        (op1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_result (rsp_result),
    .busy       (busy),
    .add_lhs    (add_lhs),
    .add_rhs    (add_rhs),
    .add_op     (add_op),
    .add_result (add_result)
  );

  // Adder model; NOP yields junk so forced-zero results are visible.
  always_comb begin
    case (add_op)
      OP_ADD:  add_result = {1'b0, add_lhs} + {1'b0, add_rhs};
      OP_SUB:  add_result = {1'b0, add_lhs} - {1'b0, add_rhs};
      default: add_result = 33'h1_2345_6789;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      chk("gnt_excl", gnt0 & gnt1, 0);
      chk("rsp_excl", rsp0_valid & rsp1_valid, 0);
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_port", rsp1_valid, e.port);
          chk("sb_result", rsp_result, e.res);
        end
      end
    end
  end

  task automatic drive_port(input logic p, input logic r,
                            input logic [2:0] op,
                            input logic [31:0] l,
                            input logic [31:0] rr);
    if (p) begin
      req1 = r; op1 = op; lhs1 = l; rhs1 = rr;
    end else begin
      req0 = r; op0 = op; lhs0 = l; rhs0 = rr;
    end
  endtask

  task automatic push_exp(input logic p, input logic [32:0] r);
    exp_t e;
    e.port = p;
    e.res  = r;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    logic [2:0] xop;
    xop = (v.op == OP_ADD || v.op == OP_SUB) ? v.op : OP_NOP;
    drive_port(v.port, 1'b1, v.op, v.lhs, v.rhs);
    push_exp(v.port, v.res);
    @(negedge clk);
    chk("gnt0", gnt0, !v.port);
    chk("gnt1", gnt1, v.port);
    chk("idle_busy", busy, 0);
    chk("idle_op", add_op, OP_NOP);
    @(posedge clk); #1;
    drive_port(v.port, 1'b0, 3'b101, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    @(negedge clk);
    chk("calc_busy", busy, 1);
    chk("calc_op", add_op, xop);
    chk("calc_lhs", add_lhs, v.lhs);
    chk("calc_rhs", add_rhs, v.rhs);
    chk("calc_gnt", gnt0 | gnt1, 0);
    chk("calc_rsp", rsp0_valid | rsp1_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_rsp0", rsp0_valid, !v.port);
    chk("done_rsp1", rsp1_valid, v.port);
    chk("done_busy", busy, 1);
    chk("done_op", add_op, OP_NOP);
    chk("done_lhs", add_lhs, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_busy", busy, 0);
    chk("hold_result", rsp_result, v.res);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1, 33'h1_0000_0000};
    vecs[1] = '{1'b1, OP_SUB, 32'd5, 32'd7, 33'h1_FFFF_FFFE};
    vecs[2] = '{1'b1, OP_ADD, 32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789};
    vecs[3] = '{1'b0, OP_SUB, 32'd10, 32'd3, 33'd7};
    vecs[4] = '{1'b0, OP_SUB, 32'd0, 32'd1, 33'h1_FFFF_FFFF};
    vecs[5] = '{1'b1, OP_NOP, 32'd9, 32'd9, 33'd0};
    vecs[6] = '{1'b0, 3'b011, 32'd3, 32'd4, 33'd0};
    vecs[7] = '{1'b1, 3'b111, 32'h8000_0000, 32'h8000_0000, 33'd0};
    vecs[8] = '{1'b1, OP_ADD, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000};

    resetn = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    op0 = OP_NOP; op1 = OP_NOP;
    lhs0 = '0; lhs1 = '0; rhs0 = '0; rhs1 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt0 | gnt1, 0);
    chk("rst_rsp", rsp0_valid | rsp1_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_op", add_op, OP_NOP);
    chk("rst_lhs", add_lhs, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both ports requesting continuously from reset.
    resetn = 1'b0;
    drive_port(1'b0, 1'b1, OP_ADD, 32'd10, 32'd20);
    drive_port(1'b1, 1'b1, OP_SUB, 32'd100, 32'd1);
    @(negedge clk);
    chk("rst_req_gnt", gnt0 | gnt1, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    push_exp(1'b0, 33'd30);
    push_exp(1'b1, 33'd99);
    push_exp(1'b0, 33'd30);
    push_exp(1'b1, 33'd99);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt0_%0d", k), gnt0, (k == 0 || k == 6));
      chk($sformatf("rr_gnt1_%0d", k), gnt1, (k == 3 || k == 9));
      chk($sformatf("rr_rsp0_%0d", k), rsp0_valid, (k == 2 || k == 8));
      chk($sformatf("rr_rsp1_%0d", k), rsp1_valid, (k == 5 || k == 11));
      @(posedge clk); #1;
      if (k == 9) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end

    // Port 1 asks while port 0 is in flight.
    drive_port(1'b0, 1'b1, OP_ADD, 32'd7, 32'd8);
    push_exp(1'b0, 33'd15);
    push_exp(1'b1, 33'd2);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("bz_gnt0_%0d", k), gnt0, (k == 0));
      chk($sformatf("bz_gnt1_%0d", k), gnt1, (k == 3));
      chk($sformatf("bz_rsp0_%0d", k), rsp0_valid, (k == 2));
      chk($sformatf("bz_rsp1_%0d", k), rsp1_valid, (k == 5));
      @(posedge clk); #1;
      if (k == 0) begin
        req0 = 1'b0;
        drive_port(1'b1, 1'b1, OP_ADD, 32'd1, 32'd1);
      end
      if (k == 3) req1 = 1'b0;
    end

    // Reset while in CALC.
    drive_port(1'b0, 1'b1, OP_ADD, 32'd2, 32'd3);
    @(negedge clk);
    chk("mid_gnt0", gnt0, 1);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk("mid_calc_busy", busy, 1);
    chk("mid_prev_result", rsp_result, 33'd2);
    #1 resetn = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_result", rsp_result, 0);
    chk("mid_rsp", rsp0_valid | rsp1_valid, 0);
    chk("mid_op", add_op, OP_NOP);
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid_norsp_%0d", k), rsp0_valid | rsp1_valid, 0);
      chk($sformatf("mid_idle_%0d", k), busy, 0);
      @(posedge clk); #1;
    end
    run_vec(vecs[0]);
    run_vec(vecs[1]);

    repeat (3) @(posedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rvm_adder_arbiter.md
# rvm_adder_arbiter

Shares the single 32-bit `rvm_adder` datapath between two requesters: port 0 (fetch / PC-increment) and port 1 (execute / address generation). A three-state sequencer latches the winning requester's operands, drives the adder for one cycle, registers the 33-bit result and returns it with a one-cycle response strobe. Arbitration is round-robin, so neither port starves. Outside an accepted operation the adder is held at NOP.

## Interface
- `RESET_PRIO`, default 0: port that wins the first simultaneous request after reset (0 or 1).
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: request from port 0 / port 1. Level-held with operands stable until accepted.
- `lhs0` / `lhs1` in 32: left operand per port.
- `rhs0` / `rhs1` in 32: right operand per port.
- `op0` / `op1` in 3: operation per port, `RVM_ARITH_*` encoding (NOP, ADD, SUB).
- `gnt0` / `gnt1` out 1: one-cycle pulse in the cycle the port's request is accepted.
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle pulse when the port's result is available.
- `rsp_result` out 33: registered result, shared by both ports. Qualified by `rspN_valid`.
- `busy` out 1: high in CALC and DONE.
- `add_lhs` / `add_rhs` out 32: operands to the adder.
- `add_op` out 3: operation to the adder.
- `add_result` in 33: result from the adder.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE:
  - `add_op` = NOP; `add_lhs` = 0; `add_rhs` = 0.
  - If any `reqN` is high: pick the winner, pulse its `gntN` combinationally in this cycle, latch its lhs/rhs/op and its index, then go to CALC.
- Arbitration:
  - One request pending: that port wins.
  - Both pending: the port not granted last wins.
  - The last-grant pointer resets to !`RESET_PRIO`, so `RESET_PRIO` wins the first tie.
  - The pointer updates only on acceptance.
- CALC:
  - Adder driven from the latched registers.
  - `add_result` captured into `rsp_result` at the end of the cycle.
  - Go to DONE.
- DONE:
  - `rspN_valid` = 1 for the latched index only.
  - `add_op` = NOP.
  - Go to IDLE.
- Latched op NOP or undefined (3'b011 and above): still runs the full sequence with `add_op` forced to NOP. `rsp_result` = 0.
- Result width: the 33 bits from the adder are passed unmodified.
  - ADD: bit 32 is the carry-out.
  - SUB: bit 32 is the borrow, i.e. the 33-bit two's-complement difference.
- Requests seen while `busy` are not accepted. They wait in IDLE.
- A requester that drops `req` after `gnt` still gets its `rsp_valid`.
- A requester whose `req` is still high in the IDLE cycle after DONE is treated as a new request.

## Timing
- Reset (asynchronous, any cycle including mid-operation):
  - State = IDLE; in-flight operation discarded, no response issued.
  - `gnt*` = 0, `rsp*_valid` = 0, `busy` = 0, `rsp_result` = 0.
  - Latched operands = 0; `add_op` = NOP; pointer reset as above.
- Latency, request sampled in IDLE at cycle t:
  - `gnt` in cycle t.
  - CALC in cycle t+1.
  - `rsp_valid` and `rsp_result` valid in cycle t+2.
  - Earliest next accept in cycle t+3.
- Throughput: one operation per 3 cycles.
- Worst-case wait for a continuously requesting port: one foreign operation, i.e. grant within 3 cycles of becoming pending.
- `rsp_result` holds its value until the next CALC capture.
- `gnt0` and `gnt1`, and `rsp0_valid` and `rsp1_valid`, are never high together.
- `add_lhs`, `add_rhs` and `add_op` change only on clock edges. They are driven from registers in CALC and are constant NOP/0 otherwise.

## Test plan
- Single ADD: `req0`, lhs=0xFFFF_FFFF, rhs=1 → `gnt0` at cycle t; `rsp0_valid` at t+2 with `rsp_result`=0x1_0000_0000; `busy` high t+1..t+2.
- Single SUB: `req1`, lhs=5, rhs=7 → `rsp1_valid` at t+2 with `rsp_result`=0x1_FFFF_FFFE; `rsp0_valid` stays 0.
- Simultaneous requests held continuously from reset with `RESET_PRIO`=0 → grants in order 0, 1, 0, 1 at cycles t, t+3, t+6, t+9; each response carries the correct port's sum.
- Request during busy: `req1` raised at t+1 while port 0 is in flight → `gnt1` at t+3; `rsp1_valid` at t+5.
- Reset mid-operation: `resetn` low during CALC → `busy`, `rsp*_valid` and `rsp_result` immediately 0; no response after release; the next request completes normally with 3-cycle latency.
- Undefined op: `op0`=3'b011, lhs=3, rhs=4 → full sequence runs; `add_op` stays NOP throughout; `rsp0_valid` at t+2 with `rsp_result`=0.
